// File: rtl/adder_arbiter_if.sv
// Bundle of requester-side and adder-side signals around adder_arbiter.
// slave = arbiter view, master = environment (requesters + adder) view.
interface adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_res;
    logic                  rsp_overflow;
    logic                  rsp_timeout;
    logic                  busy;
    logic                  add_start;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_ready;
    logic [WIDTH-1:0]      add_res;
    logic                  add_overflow;

    modport slave (
        input  req_valid, req_a, req_b, add_ready, add_res, add_overflow,
        output req_ready, rsp_valid, rsp_res, rsp_overflow, rsp_timeout,
               busy, add_start, add_a, add_b
    );

    modport master (
        output req_valid, req_a, req_b, add_ready, add_res, add_overflow,
        input  req_ready, rsp_valid, rsp_res, rsp_overflow, rsp_timeout,
               busy, add_start, add_a, add_b
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one sequential adder among NREQ requesters,
// with a watchdog that forces a timeout response if the adder never answers.
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    adder_arbiter_if.slave   bus
);
    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    last_grant_q, grant_q;
    logic [TW-1:0]    timer_q;
    logic [WIDTH-1:0] add_a_q, add_b_q, rsp_res_q;
    logic             rsp_ovf_q, rsp_to_q;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [NREQ-1:0]  above_last, req_hi;
    logic [GW-1:0]    hi_idx, lo_idx, grant_sel;
    logic             any_req, timeout_hit, accept, resp_fire;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_arr[gi]      = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]      = bus.req_b[gi*WIDTH +: WIDTH];
            assign above_last[gi] = (GW'(gi) > last_grant_q);
        end
    endgenerate

    // Requests above the last grant win; otherwise wrap to the lowest index.
    assign req_hi  = bus.req_valid & above_last;
    assign any_req = |bus.req_valid;

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_hi[i])        hi_idx = GW'(i);
            if (bus.req_valid[i]) lo_idx = GW'(i);
        end
        grant_sel = (|req_hi) ? hi_idx : lo_idx;
    end

    assign timeout_hit = (timer_q == TW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (bus.add_ready || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are masked during reset so nothing leaks out of an aborted transaction.
    always_comb begin
        accept        = (state_q == S_IDLE) && any_req && !rst;
        resp_fire     = (state_q == S_RESP) && !rst;
        bus.add_start = (state_q == S_ISSUE) && !rst;
        bus.busy      = (state_q != S_IDLE);
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = accept    && (grant_sel == GW'(i));
            bus.rsp_valid[i] = resp_fire && (grant_q   == GW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GW'(NREQ-1);
            grant_q      <= '0;
            timer_q      <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_res_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_to_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_sel;
                        add_a_q <= a_arr[grant_sel];
                        add_b_q <= b_arr[grant_sel];
                    end
                end
                S_ISSUE: timer_q <= '0;
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (bus.add_ready) begin
                        rsp_res_q <= bus.add_res;
                        rsp_ovf_q <= bus.add_overflow;
                        rsp_to_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_res_q <= '0;
                        rsp_ovf_q <= 1'b0;
                        rsp_to_q  <= 1'b1;
                    end
                end
                S_RESP:  last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    assign bus.add_a        = add_a_q;
    assign bus.add_b        = add_b_q;
    assign bus.rsp_res      = rsp_res_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_timeout  = rsp_to_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: stimulus pushes expected responses,
// a behavioural adder answers add_start, and a monitor checks every rsp_valid.
module tb_adder_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    typedef struct {
        int               grant;
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             to;
        int               cyc;
    } exp_t;

    typedef struct {
        int               lat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               cyc;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    iss_t iss_q[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   last_grant = NREQ-1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] pat);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last_grant + k) % NREQ;
            if (pat[idx]) return idx;
        end
        return -1;
    endfunction

    // lat < 0: adder never answers; lat > TIMEOUT: answers after the watchdog.
    task automatic txn(input logic [NREQ-1:0] pat, input int lat, input bit fixed,
                       input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                       input bit expect_rsp);
        logic [WIDTH-1:0] oa [NREQ];
        logic [WIDTH-1:0] ob [NREQ];
        logic [NREQ-1:0]  oh;
        logic [WIDTH:0]   sum;
        int   g, n, t;
        bit   to;
        exp_t e;
        iss_t s;
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = fixed ? fa : WIDTH'($urandom());
            ob[i] = fixed ? fb : WIDTH'($urandom());
            bus.req_a[i*WIDTH +: WIDTH] = oa[i];
            bus.req_b[i*WIDTH +: WIDTH] = ob[i];
        end
        bus.req_valid = pat;
        g  = rr_pick(pat);
        oh = '0;
        oh[g] = 1'b1;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < TIMEOUT + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(oh));
        if (bus.req_ready == '0) return;
        t   = cyc;
        to  = (lat < 0) || (lat > TIMEOUT);
        sum = {1'b0, oa[g]} + {1'b0, ob[g]};
        s = '{lat, oa[g], ob[g], t};
        iss_q.push_back(s);
        if (expect_rsp) begin
            e = '{g, to ? '0 : sum[WIDTH-1:0], to ? 1'b0 : sum[WIDTH], to,
                  t + 2 + (to ? TIMEOUT : lat)};
            exp_q.push_back(e);
        end
        last_grant = g;
        @(negedge clk);
    endtask

    // Behavioural sequential adder: answers lat cycles after add_start.
    initial begin
        iss_t s;
        logic [WIDTH:0] sum;
        bus.add_ready    = 1'b0;
        bus.add_res      = '0;
        bus.add_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.add_start === 1'b1) begin
                if (iss_q.size() == 0) begin
                    chk("unexpected_start", 64'(bus.add_start), 64'(0));
                end else begin
                    s = iss_q.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(s.cyc + 1));
                    chk("add_a", 64'(bus.add_a), 64'(s.a));
                    chk("add_b", 64'(bus.add_b), 64'(s.b));
                    if (s.lat > 0) begin
                        sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
                        repeat (s.lat) @(negedge clk);
                        bus.add_ready    = 1'b1;
                        bus.add_res      = sum[WIDTH-1:0];
                        bus.add_overflow = sum[WIDTH];
                        @(negedge clk);
                        bus.add_ready    = 1'b0;
                        bus.add_res      = WIDTH'($urandom());
                        bus.add_overflow = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: every response pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.grant] = 1'b1;
                    $display("[TB] rsp grant=%0d res=%0h ovf=%0b to=%0b cyc=%0d",
                             e.grant, bus.rsp_res, bus.rsp_overflow, bus.rsp_timeout, cyc);
                    chk("rsp_valid",    64'(bus.rsp_valid),    64'(oh));
                    chk("rsp_res",      64'(bus.rsp_res),      64'(e.res));
                    chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(e.ovf));
                    chk("rsp_timeout",  64'(bus.rsp_timeout),  64'(e.to));
                    chk("rsp_cycle",    64'(cyc),              64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
        bus.req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy",      64'(bus.busy),         64'(0));
        chk("rst_req_ready", 64'(bus.req_ready),    64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid),    64'(0));
        chk("rst_add_start", 64'(bus.add_start),    64'(0));
        chk("rst_add_a",     64'(bus.add_a),        64'(0));
        chk("rst_add_b",     64'(bus.add_b),        64'(0));
        chk("rst_rsp_res",   64'(bus.rsp_res),      64'(0));
        chk("rst_rsp_ovf",   64'(bus.rsp_overflow), 64'(0));
        chk("rst_rsp_to",    64'(bus.rsp_timeout),  64'(0));

        txn(4'b0001, 3, 1'b1, 32'd5, 32'd7, 1'b1);
        repeat (4) txn(4'b1111, int'($urandom_range(1, 6)), 1'b0, '0, '0, 1'b1);
        txn(4'b0100, 2, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        txn(4'b1000, -1, 1'b0, '0, '0, 1'b1);
        txn(4'b1111, TIMEOUT + 1, 1'b0, '0, '0, 1'b1);
        txn(4'b1111, TIMEOUT, 1'b0, '0, '0, 1'b1);
        txn(4'b0010, 4, 1'b0, '0, '0, 1'b1);

        // Abort a transaction in WAIT; arbitration must restart from requester 0.
        txn(4'b0001, -1, 1'b0, '0, '0, 1'b0);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy",      64'(bus.busy),      64'(0));
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("abort_add_start", 64'(bus.add_start), 64'(0));
        last_grant = NREQ-1;
        txn(4'b1111, 2, 1'b0, '0, '0, 1'b1);

        repeat (30) txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                        int'($urandom_range(1, 10)), 1'b0, '0, '0, 1'b1);

        bus.req_valid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
